// File: rtl/fpu_sched_pkg.sv
// Shared types and opcode encodings for the FPU issue scheduler.
package fpu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FLUSH,
        RESP
    } sched_state_t;

    localparam logic [7:0] OP_FADD  = 8'h01;
    localparam logic [7:0] OP_FSUB  = 8'h02;
    localparam logic [7:0] OP_FMUL  = 8'h04;
    localparam logic [7:0] OP_FDIV  = 8'h08;
    localparam logic [7:0] OP_FSQRT = 8'h10;
    localparam logic [7:0] OP_FTOI  = 8'h20;
    localparam logic [7:0] OP_ITOF  = 8'h40;
    localparam logic [7:0] OP_FABS  = 8'h80;

    function automatic logic op_legal(input logic [7:0] op);
        return $onehot(op);
    endfunction

endpackage

// File: rtl/fpu_issue_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer, cyclically.
module rr_arbiter #(
    parameter  int N   = 2,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic           any_o
);

    localparam int unsigned NU = N;

    logic [IDW-1:0] idx;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int unsigned off = 0; off < NU; off++) begin
            idx = IDW'((32'(ptr_i) + off) % NU);
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_issue_sched.sv
// Shares one fpu_top between NREQ requesters: round-robin grant, single-cycle issue, timeout recovery.
module fpu_issue_sched
    import fpu_sched_pkg::*;
#(
    parameter  int NREQ    = 2,
    parameter  int TIMEOUT = 64,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*8-1:0]    req_op,
    input  logic [NREQ*32-1:0]   req_x1,
    input  logic [NREQ*32-1:0]   req_x2,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_y,
    output logic                 rsp_ovf,
    output logic                 rsp_unf,
    output logic                 rsp_err,
    output logic [7:0]           fpu_opcode,
    output logic [31:0]          fpu_x1,
    output logic [31:0]          fpu_x2,
    output logic                 fpu_rstn,
    input  logic [31:0]          fpu_y,
    input  logic                 fpu_ovf,
    input  logic                 fpu_unf,
    input  logic                 fpu_out_valid
);

    localparam int CW = $clog2(TIMEOUT);

    sched_state_t   state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     op_q, op_d;
    logic [31:0]    x1_q, x1_d, x2_q, x2_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [31:0]    ry_q, ry_d;
    logic           rovf_q, rovf_d, runf_q, runf_d, rerr_q, rerr_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic [7:0]      sel_op;
    logic [31:0]     sel_x1, sel_x2;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .any_o    (gnt_any)
    );

    assign sel_op = req_op[32'(gnt_id)*8 +: 8];
    assign sel_x1 = req_x1[32'(gnt_id)*32 +: 32];
    assign sel_x2 = req_x2[32'(gnt_id)*32 +: 32];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            cnt_q   <= '0;
            rid_q   <= '0;
            ry_q    <= '0;
            rovf_q  <= 1'b0;
            runf_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            cnt_q   <= cnt_d;
            rid_q   <= rid_d;
            ry_q    <= ry_d;
            rovf_q  <= rovf_d;
            runf_q  <= runf_d;
            rerr_q  <= rerr_d;
        end
    end

    // Response registers are only written on entry to RESP so rsp_* hold between responses.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        cnt_d   = cnt_q;
        rid_d   = rid_q;
        ry_d    = ry_q;
        rovf_d  = rovf_q;
        runf_d  = runf_q;
        rerr_d  = rerr_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    id_d = gnt_id;
                    op_d = sel_op;
                    x1_d = sel_x1;
                    x2_d = sel_x2;
                    if (op_legal(sel_op)) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = RESP;
                        rid_d   = gnt_id;
                        ry_d    = '0;
                        rovf_d  = 1'b0;
                        runf_d  = 1'b0;
                        rerr_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (fpu_out_valid) begin
                    state_d = RESP;
                    rid_d   = id_q;
                    ry_d    = fpu_y;
                    rovf_d  = fpu_ovf;
                    runf_d  = fpu_unf;
                    rerr_d  = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d = RESP;
                rid_d   = id_q;
                ry_d    = '0;
                rovf_d  = 1'b0;
                runf_d  = 1'b0;
                rerr_d  = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (rid_q == IDW'(NREQ - 1)) ? '0 : rid_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        fpu_opcode = '0;
        rsp_valid  = 1'b0;
        fpu_rstn   = ~rst;
        unique case (state_q)
            IDLE:    req_ready  = rst ? '0 : gnt;
            ISSUE:   fpu_opcode = op_q;
            FLUSH:   fpu_rstn   = 1'b0;
            RESP:    rsp_valid  = 1'b1;
            default: ;
        endcase
    end

    assign rsp_id  = rid_q;
    assign rsp_y   = ry_q;
    assign rsp_ovf = rovf_q;
    assign rsp_unf = runf_q;
    assign rsp_err = rerr_q;
    assign fpu_x1  = x1_q;
    assign fpu_x2  = x2_q;

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched: event-time reference model, stub FPU, directed cases then random traffic.
module tb_fpu_issue_sched;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic              sys_clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_op = '0;
    logic [NREQ*32-1:0] req_x1 = '0;
    logic [NREQ*32-1:0] req_x2 = '0;
    logic              rsp_valid;
    logic [0:0]        rsp_id;
    logic [31:0]       rsp_y;
    logic              rsp_ovf, rsp_unf, rsp_err;
    logic [7:0]        fpu_opcode;
    logic [31:0]       fpu_x1, fpu_x2;
    logic              fpu_rstn;
    logic [31:0]       fpu_y = '0;
    logic              fpu_ovf = 1'b0, fpu_unf = 1'b0, fpu_out_valid = 1'b0;

    fpu_issue_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x1(req_x1), .req_x2(req_x2),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_err(rsp_err),
        .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_rstn(fpu_rstn),
        .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf), .fpu_out_valid(fpu_out_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0, n_err = 0, cyc = 0;

    // Pending request per requester (what each requester is presenting)
    bit          pv [NREQ];
    logic [7:0]  pop[NREQ];
    logic [31:0] px1[NREQ], px2[NREQ];

    // Reference model: in-flight operation and the cycles at which its events are due
    bit          busy_m = 0, cur_legal = 0, rnd_mode = 0, hang_force = 0, hang_cur = 0;
    int          ptr_m = 0, cur_id = 0, exp_op_c = -1, exp_flush_c = -1, exp_rsp_c = -1;
    int          lat_force = 0, lat_cur = 1, ov_at = -1;
    logic [7:0]  cur_op;
    logic [31:0] cur_x1, cur_x2;
    logic [33:0] exp_r, stub_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stub FPU result: {unf, ovf, y}
    function automatic logic [33:0] fmodel(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] h;
        if (op == 8'h01 && a == 32'h3f800000 && b == 32'h40000000) return {2'b00, 32'h40400000};
        if (op == 8'h04 && a == 32'h40000000 && b == 32'h40400000) return {2'b00, 32'h40c00000};
        if (op == 8'h04 && a == 32'h7f000000 && b == 32'h7f000000) return {2'b01, 32'h7f800000};
        h = a ^ {b[15:0], b[31:16]} ^ {4{op}};
        return {h[7], h[3], h};
    endfunction

    task automatic step(input bit do_rst);
        logic [NREQ-1:0] exp_rdy;
        bit spur, rsp_now;
        @(negedge sys_clk);
        if (rnd_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pv[i] && $urandom_range(0, 15) == 0) pv[i] = 0;
                else if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i]  = 1;
                    pop[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
                    px1[i] = $urandom;
                    px2[i] = $urandom;
                end
            end
        end
        rst = do_rst;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pv[i];
            req_op[i*8 +: 8]    = pop[i];
            req_x1[i*32 +: 32]  = px1[i];
            req_x2[i*32 +: 32]  = px2[i];
        end
        spur = rnd_mode && (ov_at != cyc) && (!busy_m || cyc == exp_op_c || cyc == exp_rsp_c)
               && ($urandom_range(0, 7) == 0);
        if (cyc == ov_at) begin
            fpu_out_valid = 1'b1;
            {fpu_unf, fpu_ovf, fpu_y} = stub_r;
        end else begin
            fpu_out_valid = spur;
            fpu_y = $urandom;
            {fpu_unf, fpu_ovf} = 2'($urandom);
        end
        #1;
        exp_rdy = '0;
        if (!do_rst && !busy_m)
            for (int off = 0; off < NREQ; off++)
                if (exp_rdy == '0 && pv[(ptr_m + off) % NREQ]) exp_rdy[(ptr_m + off) % NREQ] = 1'b1;
        rsp_now = busy_m && cyc == exp_rsp_c;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("fpu_opcode", 32'(fpu_opcode), (busy_m && cyc == exp_op_c) ? 32'(cur_op) : 32'd0);
        chk("fpu_rstn", 32'(fpu_rstn), (do_rst || (busy_m && cyc == exp_flush_c)) ? 32'd0 : 32'd1);
        chk("rsp_valid", 32'(rsp_valid), 32'(rsp_now));
        if (rsp_now) begin
            chk("rsp_id", 32'(rsp_id), 32'(cur_id));
            chk("rsp_y", rsp_y, exp_r[31:0]);
            chk("rsp_ovf", 32'(rsp_ovf), 32'(exp_r[32]));
            chk("rsp_unf", 32'(rsp_unf), 32'(exp_r[33]));
            chk("rsp_err", 32'(rsp_err), cur_legal && !hang_cur ? 32'd0 : 32'd1);
        end
        if (busy_m && cur_legal && cyc >= exp_op_c && cyc < exp_rsp_c) begin
            chk("fpu_x1_hold", fpu_x1, cur_x1);
            chk("fpu_x2_hold", fpu_x2, cur_x2);
        end
        if (cyc == ov_at) ov_at = -1;
        if (fpu_opcode != 8'h00 && !hang_cur) begin
            ov_at  = cyc + lat_cur;
            stub_r = fmodel(fpu_opcode, fpu_x1, fpu_x2);
        end
        if (do_rst) begin
            busy_m = 0;
            ptr_m  = 0;
        end else begin
            if (rsp_now) begin
                busy_m = 0;
                ptr_m  = (cur_id + 1) % NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (pv[i] && exp_rdy[i]) begin
                    pv[i]     = 0;
                    busy_m    = 1;
                    cur_id    = i;
                    cur_op    = pop[i];
                    cur_x1    = px1[i];
                    cur_x2    = px2[i];
                    cur_legal = $onehot(pop[i]);
                    hang_cur  = cur_legal && (hang_force || (rnd_mode && $urandom_range(0, 29) == 0));
                    lat_cur   = (lat_force != 0) ? lat_force :
                                (rnd_mode && $urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(1, 6);
                    exp_flush_c = -1;
                    if (!cur_legal) begin
                        exp_op_c  = -1;
                        exp_rsp_c = cyc + 1;
                        exp_r     = '0;
                    end else if (hang_cur) begin
                        exp_op_c    = cyc + 1;
                        exp_flush_c = cyc + 2 + TIMEOUT;
                        exp_rsp_c   = cyc + 3 + TIMEOUT;
                        exp_r       = '0;
                    end else begin
                        exp_op_c  = cyc + 1;
                        exp_rsp_c = cyc + 2 + lat_cur;
                        exp_r     = fmodel(cur_op, cur_x1, cur_x2);
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (!busy_m && !pv[0] && !pv[1]) break;
            step(1'b0);
        end
        chk("drain_idle", {30'd0, busy_m, pv[0] | pv[1]}, 32'd0);
    endtask

    task automatic put(input int i, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        pv[i] = 1; pop[i] = op; px1[i] = a; px2[i] = b;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 0; pop[i] = '0; px1[i] = '0; px2[i] = '0;
        end
        step(1'b1);
        step(1'b1);
        chk("reset_rsp_y", rsp_y, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        step(1'b0);

        // fadd 1.0 + 2.0
        lat_force = 3;
        put(0, 8'h01, 32'h3f800000, 32'h40000000);
        drain();

        // simultaneous pair right after reset, then pointer left at req1
        step(1'b1);
        put(0, 8'h04, 32'h40000000, 32'h40400000);
        put(1, 8'h02, 32'h40400000, 32'h3f800000);
        drain();
        put(0, 8'h08, 32'h12345678, 32'h9abcdef0);
        drain();
        put(0, 8'h04, 32'h40000000, 32'h40400000);
        put(1, 8'h10, 32'h40800000, 32'h00000000);
        drain();

        // illegal opcode
        put(1, 8'h03, 32'h11111111, 32'h22222222);
        drain();

        // hung FPU, then a normal op
        hang_force = 1;
        put(0, 8'h01, 32'hdeadbeef, 32'h01234567);
        drain();
        hang_force = 0;
        put(1, 8'h20, 32'h40490fdb, 32'h0);
        drain();

        // overflow flag
        put(0, 8'h04, 32'h7f000000, 32'h7f000000);
        drain();

        // result on the last WAIT cycle beats the timeout
        lat_force = TIMEOUT;
        put(1, 8'h80, 32'hbf800000, 32'h0);
        drain();

        // reset during WAIT; late result lands in the following IDLE cycle
        lat_force = 4;
        put(0, 8'h40, 32'h00000007, 32'h0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        put(1, 8'h01, 32'h3f800000, 32'h40000000);
        step(1'b1);
        lat_force = 2;
        drain();
        lat_force = 0;

        rnd_mode = 1;
        for (int k = 0; k < 2000; k++) step(1'b0);
        rnd_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
